// File: rtl/id_hazard_if.sv
// id_hazard_if: decode-stage hazard signals between the ID stage and the hazard unit.
// Stats outputs exist only when HAZARD_STATS_EN is defined.
interface id_hazard_if #(parameter int STAT_W = 32);
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] id_rd;
    logic       id_rd_wr;
    logic       id_is_load;
    logic       ex_flush;
    logic       stall_if_id;
    logic       bubble_id_ex;
    logic       forward;
    logic [4:0] ex_stage_rd;
    logic [4:0] mem_stage_rd;
    logic [4:0] wb_stage_rd;
    logic [1:0] fwd_rs1_src;
    logic [1:0] fwd_rs2_src;
`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] stat_stall_cnt;
    logic [STAT_W-1:0] stat_flush_cnt;
    logic [STAT_W-1:0] stat_fwd_cnt;
`endif
    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_wr, id_is_load, ex_flush,
        input  stall_if_id, bubble_id_ex, forward, ex_stage_rd, mem_stage_rd, wb_stage_rd, fwd_rs1_src, fwd_rs2_src
`ifdef HAZARD_STATS_EN
        , input stat_stall_cnt, stat_flush_cnt, stat_fwd_cnt
`endif
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_wr, id_is_load, ex_flush,
        output stall_if_id, bubble_id_ex, forward, ex_stage_rd, mem_stage_rd, wb_stage_rd, fwd_rs1_src, fwd_rs2_src
`ifdef HAZARD_STATS_EN
        , output stat_stall_cnt, stat_flush_cnt, stat_fwd_cnt
`endif
    );
endinterface

// File: rtl/id_hazard_unit.sv
// id_hazard_unit: load-use stall, flush squash and forwarding control from a 3-slot rd shadow pipeline.
// Optional saturating statistics counters under HAZARD_STATS_EN.
module id_hazard_unit #(
    parameter int LOAD_USE_STALL = 1,
    parameter int STAT_W         = 32
) (
    input logic       clk,
    input logic       rst,
    id_hazard_if.slave h
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] STALL = 1'b1;
    logic [0:0] state;
    logic [1:0] cnt;
    logic       ex_v, ex_ld, mem_v, wb_v;
    logic [4:0] ex_rd, mem_rd, wb_rd, park;
    logic       s1e, s1m, s1w, s2e, s2m, s2w, hazard, take;
    // Invalid slots show an index that neither current source can match.
    assign park = (h.id_rs1 != 5'd1 && h.id_rs2 != 5'd1) ? 5'd1 :
                  (h.id_rs1 != 5'd2 && h.id_rs2 != 5'd2) ? 5'd2 : 5'd3;
    assign s1e = h.id_rs1_used && ex_v  && ex_rd  == h.id_rs1;
    assign s1m = h.id_rs1_used && mem_v && mem_rd == h.id_rs1;
    assign s1w = h.id_rs1_used && wb_v  && wb_rd  == h.id_rs1;
    assign s2e = h.id_rs2_used && ex_v  && ex_rd  == h.id_rs2;
    assign s2m = h.id_rs2_used && mem_v && mem_rd == h.id_rs2;
    assign s2w = h.id_rs2_used && wb_v  && wb_rd  == h.id_rs2;
    assign hazard = h.id_valid && ex_ld && (s1e || s2e);
    assign h.fwd_rs1_src  = s1e ? 2'd1 : s1m ? 2'd2 : s1w ? 2'd3 : 2'd0;
    assign h.fwd_rs2_src  = s2e ? 2'd1 : s2m ? 2'd2 : s2w ? 2'd3 : 2'd0;
    assign h.forward      = s1e || s1m || s1w || s2e || s2m || s2w;
    assign h.ex_stage_rd  = ex_v  ? ex_rd  : park;
    assign h.mem_stage_rd = mem_v ? mem_rd : park;
    assign h.wb_stage_rd  = wb_v  ? wb_rd  : park;
    assign h.stall_if_id  = !h.ex_flush && (state == STALL || hazard);
    assign h.bubble_id_ex = h.ex_flush || h.stall_if_id;
    assign take = h.id_valid && !h.stall_if_id && !h.ex_flush;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_v   <= 1'b0;
            ex_rd  <= 5'd0;
            ex_ld  <= 1'b0;
            mem_v  <= 1'b0;
            mem_rd <= 5'd0;
            wb_v   <= 1'b0;
            wb_rd  <= 5'd0;
            state  <= IDLE;
            cnt    <= 2'd0;
        end else begin
            wb_v   <= mem_v;
            wb_rd  <= mem_rd;
            mem_v  <= ex_v;
            mem_rd <= ex_rd;
            ex_v   <= take && h.id_rd_wr && h.id_rd != 5'd0;
            ex_rd  <= take ? h.id_rd : 5'd0;
            ex_ld  <= take && h.id_is_load && h.id_rd_wr && h.id_rd != 5'd0;
            if (h.ex_flush) begin
                state <= IDLE;
                cnt   <= 2'd0;
            end else if (state == IDLE) begin
                if (hazard) begin
                    state <= (LOAD_USE_STALL > 1) ? STALL : IDLE;
                    cnt   <= 2'(LOAD_USE_STALL - 1);
                end
            end else begin
                state <= (cnt <= 2'd1) ? IDLE : STALL;
                cnt   <= (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
            end
        end
    end
`ifdef HAZARD_STATS_EN
    localparam logic [STAT_W-1:0] SAT = '1;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h.stat_stall_cnt <= '0;
            h.stat_flush_cnt <= '0;
            h.stat_fwd_cnt   <= '0;
        end else begin
            if (h.stall_if_id && h.stat_stall_cnt != SAT) h.stat_stall_cnt <= h.stat_stall_cnt + 1'b1;
            if (h.ex_flush && h.stat_flush_cnt != SAT) h.stat_flush_cnt <= h.stat_flush_cnt + 1'b1;
            if (h.forward && h.id_valid && h.stat_fwd_cnt != SAT) h.stat_fwd_cnt <= h.stat_fwd_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_id_hazard_unit.sv
// tb_id_hazard_unit: directed checks of id_hazard_unit with LOAD_USE_STALL=1 (u1) and 3 (u3).
module tb_id_hazard_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    id_hazard_if i1();
    id_hazard_if i3();
    id_hazard_unit #(.LOAD_USE_STALL(1)) u1 (.clk(clk), .rst(rst), .h(i1.slave));
    id_hazard_unit #(.LOAD_USE_STALL(3)) u3 (.clk(clk), .rst(rst), .h(i3.slave));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic u1_,
                          input logic u2_, input logic [4:0] rd, input logic wr, input logic ld);
        i1.id_valid = v; i1.id_rs1 = r1; i1.id_rs2 = r2; i1.id_rs1_used = u1_; i1.id_rs2_used = u2_;
        i1.id_rd = rd; i1.id_rd_wr = wr; i1.id_is_load = ld;
        i3.id_valid = v; i3.id_rs1 = r1; i3.id_rs2 = r2; i3.id_rs1_used = u1_; i3.id_rs2_used = u2_;
        i3.id_rd = rd; i3.id_rd_wr = wr; i3.id_is_load = ld;
    endtask

    task automatic flush(input logic f);
        i1.ex_flush = f;
        i3.ex_flush = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    initial begin
        flush(1'b0);
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        #3;
        chk("rst_stall", int'(i1.stall_if_id), 0);
        chk("rst_bubble", int'(i1.bubble_id_ex), 0);
        chk("rst_forward", int'(i1.forward), 0);
        chk("rst_ex_park", int'(i1.ex_stage_rd), 1);
        chk("rst_mem_park", int'(i1.mem_stage_rd), 1);
        chk("rst_wb_park", int'(i1.wb_stage_rd), 1);
        chk("rst_stall3", int'(i3.stall_if_id), 0);
        tick();
        rst = 1'b1;
        // ALU result forwarded from EX
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0);
        #1;
        chk("alu_forward", int'(i1.forward), 1);
        chk("alu_rs1_src", int'(i1.fwd_rs1_src), 1);
        chk("alu_rs2_src", int'(i1.fwd_rs2_src), 0);
        chk("alu_ex_rd", int'(i1.ex_stage_rd), 5);
        chk("alu_mem_park", int'(i1.mem_stage_rd), 1);
        chk("alu_no_stall", int'(i1.stall_if_id), 0);
        // load-use, both stall lengths
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
        #1;
        chk("lw_issue_stall", int'(i1.stall_if_id), 0);
        tick();
        set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0);
        #1;
        chk("lu1_stall", int'(i1.stall_if_id), 1);
        chk("lu1_bubble", int'(i1.bubble_id_ex), 1);
        chk("lu1_rs1_src_in_stall", int'(i1.fwd_rs1_src), 1);
        chk("lu3_stall_c1", int'(i3.stall_if_id), 1);
        tick();
        chk("lu1_after_stall", int'(i1.stall_if_id), 0);
        chk("lu1_after_bubble", int'(i1.bubble_id_ex), 0);
        chk("lu1_rs1_src_mem", int'(i1.fwd_rs1_src), 2);
        chk("lu1_mem_rd", int'(i1.mem_stage_rd), 7);
        chk("lu3_stall_c2", int'(i3.stall_if_id), 1);
        chk("lu3_rs1_src_c2", int'(i3.fwd_rs1_src), 2);
        tick();
        chk("lu3_stall_c3", int'(i3.stall_if_id), 1);
        chk("lu3_rs1_src_c3", int'(i3.fwd_rs1_src), 3);
        chk("lu1_rs1_src_wb", int'(i1.fwd_rs1_src), 3);
        tick();
        chk("lu3_stall_done", int'(i3.stall_if_id), 0);
        chk("lu3_bubble_done", int'(i3.bubble_id_ex), 0);
        chk("lu3_rs1_src_done", int'(i3.fwd_rs1_src), 0);
        // flush during the second stall cycle
        tick();
        do_reset();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0);
        #1;
        chk("fl_stall_c1", int'(i3.stall_if_id), 1);
        tick();
        chk("fl_stall_c2", int'(i3.stall_if_id), 1);
        flush(1'b1);
        #1;
        chk("fl_stall_drop", int'(i3.stall_if_id), 0);
        chk("fl_bubble", int'(i3.bubble_id_ex), 1);
        tick();
        flush(1'b0);
        #1;
        chk("fl_idle_stall", int'(i3.stall_if_id), 0);
        chk("fl_idle_bubble", int'(i3.bubble_id_ex), 0);
        chk("fl_ex_park", int'(i3.ex_stage_rd), 1);
        // x0 writes never forward
        do_reset();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd1, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0);
        #1;
        chk("x0_forward", int'(i1.forward), 0);
        chk("x0_ex_park", int'(i1.ex_stage_rd), 2);
        chk("x0_mem_park", int'(i1.mem_stage_rd), 2);
        chk("x0_wb_park", int'(i1.wb_stage_rd), 2);
        // EX beats WB for the same rd
        do_reset();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        chk("pri_rs1_src", int'(i1.fwd_rs1_src), 2);
        chk("pri_rs2_src", int'(i1.fwd_rs2_src), 1);
        chk("pri_ex_rd", int'(i1.ex_stage_rd), 9);
        chk("pri_mem_rd", int'(i1.mem_stage_rd), 8);
        chk("pri_wb_rd", int'(i1.wb_stage_rd), 9);
        set_id(1'b0, 5'd8, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        chk("inv_forward", int'(i1.forward), 1);
        chk("inv_rs2_src", int'(i1.fwd_rs2_src), 1);
        chk("inv_bubble", int'(i1.bubble_id_ex), 0);
        // asynchronous reset in the middle of a stall
        do_reset();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b1);
        tick();
        set_id(1'b0, 5'd12, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("inv_no_hazard", int'(i1.stall_if_id), 0);
        set_id(1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("ar_stall1", int'(i1.stall_if_id), 1);
        chk("ar_stall3", int'(i3.stall_if_id), 1);
        rst = 1'b0;
        #1;
        chk("ar_async_stall1", int'(i1.stall_if_id), 0);
        chk("ar_async_stall3", int'(i3.stall_if_id), 0);
        chk("ar_async_bubble3", int'(i3.bubble_id_ex), 0);
        rst = 1'b1;
        tick();
        chk("ar_post_forward1", int'(i1.forward), 0);
        chk("ar_post_forward3", int'(i3.forward), 0);
        chk("ar_post_stall3", int'(i3.stall_if_id), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
